// File: rtl/ledg_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ledg_pattern_sequencer
// Description : Autonomous pattern generator for the green-LED PIO register.
//               Software configures a mode, seed and rate through a small
//               Avalon slave. The block then produces one-cycle Avalon write
//               strobes to the LED PIO (address 0) on every prescaler tick,
//               so software does not have to write every frame.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             system clock
//   reset           asynchronous, active-high reset
//   cpu_address     config register select (0 CTRL, 1 PATTERN, 2 RATE)
//   cpu_chipselect  config slave select
//   cpu_write_n     config write strobe, active low
//   cpu_writedata   config write data
//   pio_address     PIO address, tied to 0
//   pio_chipselect  PIO write strobe, active high, one cycle per update
//   pio_write_n     PIO write enable, active low
//   pio_writedata   pattern written to the PIO, held between strobes
//   busy            enable set, or a PIO write is in progress
// Register map
//   0 CTRL    bit0 enable, bits2:1 mode (00 static, 01 rotate-left,
//             10 bounce, 11 binary count)
//   1 PATTERN seed, loaded into the pattern register and written out at once
//   2 RATE    8-bit rate; tick period is (rate+1) * 2**PRESCALE_SHIFT cycles
//   3         ignored
// WIDTH must be at least 3 so the CTRL fields fit in the write data.
// ============================================================================
module ledg_pattern_sequencer #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_SHIFT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cpu_address,
  input  logic             cpu_chipselect,
  input  logic             cpu_write_n,
  input  logic [WIDTH-1:0] cpu_writedata,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [WIDTH-1:0] pio_writedata,
  output logic             busy
);

  localparam int CNT_W = PRESCALE_SHIFT + 8;

  // Low PRESCALE_SHIFT bits set; written this way so PRESCALE_SHIFT=0 is legal.
  localparam logic [CNT_W-1:0] c_low_ones = {CNT_W{1'b1}} >> 8;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_run    = 2'd1;
  localparam logic [1:0] c_st_strobe = 2'd2;

  localparam logic [1:0] c_mode_static = 2'd0;
  localparam logic [1:0] c_mode_rotate = 2'd1;
  localparam logic [1:0] c_mode_bounce = 2'd2;
  localparam logic [1:0] c_mode_count  = 2'd3;

  localparam logic c_dir_left  = 1'b0;
  localparam logic c_dir_right = 1'b1;

  // Architectural state
  logic [2:0]       ctrl_q,    ctrl_d;
  logic [7:0]       rate_q,    rate_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic             dir_q,     dir_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       state_q,   state_d;

  // Registered PIO bus
  logic             pio_cs_q,   pio_cs_d;
  logic             pio_wn_q,   pio_wn_d;
  logic [WIDTH-1:0] pio_data_q, pio_data_d;

  // Decode
  logic             w_cfg_wr;
  logic             w_wr_ctrl;
  logic             w_wr_pat;
  logic             w_wr_rate;
  logic             w_enable;
  logic [1:0]       w_mode;
  logic [CNT_W-1:0] w_terminal;
  logic             w_tick;
  logic             w_step;
  logic             w_strobe;
  logic [WIDTH-1:0] w_next_pat;
  logic             w_next_dir;

  assign w_cfg_wr  = cpu_chipselect & ~cpu_write_n;
  assign w_wr_ctrl = w_cfg_wr & (cpu_address == 2'd0);
  assign w_wr_pat  = w_cfg_wr & (cpu_address == 2'd1);
  assign w_wr_rate = w_cfg_wr & (cpu_address == 2'd2);

  assign w_enable   = ctrl_q[0];
  assign w_mode     = ctrl_q[2:1];
  assign w_terminal = (CNT_W'(rate_q) << PRESCALE_SHIFT) | c_low_ones;
  assign w_tick     = w_enable & (cnt_q == w_terminal);

  // A tick only advances the pattern when no PATTERN or CTRL write competes
  // with it: a seed write takes priority, and a CTRL write may change the
  // enable or mode the tick was generated under.
  assign w_step   = w_tick & ~w_wr_pat & ~w_wr_ctrl & (w_mode != c_mode_static);
  assign w_strobe = w_wr_pat | w_step;

  // Next-pattern function
  always_comb begin
    w_next_pat = pattern_q;
    w_next_dir = dir_q;
    case (w_mode)
      c_mode_rotate: w_next_pat = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
      c_mode_bounce: begin
        if (dir_q == c_dir_left) begin
          if (pattern_q[WIDTH-1]) begin
            w_next_dir = c_dir_right;
            w_next_pat = pattern_q >> 1;
          end else begin
            w_next_pat = pattern_q << 1;
          end
        end else begin
          if (pattern_q[0]) begin
            w_next_dir = c_dir_left;
            w_next_pat = pattern_q << 1;
          end else begin
            w_next_pat = pattern_q >> 1;
          end
        end
      end
      c_mode_count:  w_next_pat = pattern_q + WIDTH'(1);
      default:       w_next_pat = pattern_q;
    endcase
  end

  // Configuration, prescaler and pattern update
  always_comb begin
    ctrl_d    = ctrl_q;
    rate_d    = rate_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q + CNT_W'(1);

    if (w_wr_ctrl) begin
      ctrl_d = cpu_writedata[2:0];
      dir_d  = c_dir_left;
    end
    if (w_wr_rate) begin
      rate_d = 8'(cpu_writedata);
    end

    // The prescaler restarts whenever any configuration changes so a new
    // rate or seed always gets a full period before the next step.
    if (!w_enable || w_wr_ctrl || w_wr_pat || w_wr_rate || w_tick) begin
      cnt_d = '0;
    end

    if (w_wr_pat) begin
      pattern_d = cpu_writedata;
      dir_d     = c_dir_left;
    end else if (w_step) begin
      pattern_d = w_next_pat;
      dir_d     = w_next_dir;
    end
  end

  // Sequencer: STROBE lasts exactly one cycle; a new strobe request in that
  // cycle simply re-enters STROBE, giving back-to-back writes.
  always_comb begin
    case (state_q)
      c_st_idle, c_st_run, c_st_strobe: begin
        if (w_strobe) begin
          state_d = c_st_strobe;
        end else if (ctrl_d[0]) begin
          state_d = c_st_run;
        end else begin
          state_d = c_st_idle;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  always_comb begin
    pio_cs_d   = (state_d == c_st_strobe);
    pio_wn_d   = ~pio_cs_d;
    pio_data_d = pio_cs_d ? pattern_d : pio_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      rate_q     <= '0;
      pattern_q  <= '0;
      dir_q      <= c_dir_left;
      cnt_q      <= '0;
      state_q    <= c_st_idle;
      pio_cs_q   <= 1'b0;
      pio_wn_q   <= 1'b1;
      pio_data_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      rate_q     <= rate_d;
      pattern_q  <= pattern_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      pio_cs_q   <= pio_cs_d;
      pio_wn_q   <= pio_wn_d;
      pio_data_q <= pio_data_d;
    end
  end

  assign pio_address    = 2'd0;
  assign pio_chipselect = pio_cs_q;
  assign pio_write_n    = pio_wn_q;
  assign pio_writedata  = pio_data_q;
  assign busy           = ctrl_q[0] | (state_q == c_st_strobe);

endmodule
`default_nettype wire

// File: tb/tb_ledg_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ledg_pattern_sequencer
// Description : Directed self-checking bench for ledg_pattern_sequencer with
//               PRESCALE_SHIFT=2 (tick period (rate+1)*4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ledg_pattern_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   cpu_address;
  logic         cpu_chipselect;
  logic         cpu_write_n;
  logic [W-1:0] cpu_writedata;
  logic [1:0]   pio_address;
  logic         pio_chipselect;
  logic         pio_write_n;
  logic [W-1:0] pio_writedata;
  logic         busy;

  int nchecks = 0;
  int nerr    = 0;

  ledg_pattern_sequencer #(.WIDTH(W), .PRESCALE_SHIFT(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_address    (cpu_address),
    .cpu_chipselect (cpu_chipselect),
    .cpu_write_n    (cpu_write_n),
    .cpu_writedata  (cpu_writedata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // One config write; returns on the negedge right after the write edge.
  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_chipselect = 1'b1;
    cpu_write_n    = 1'b0;
    cpu_address    = a;
    cpu_writedata  = d;
    @(negedge clk);
    cpu_chipselect = 1'b0;
    cpu_write_n    = 1'b1;
  endtask

  // Waits (bounded) for the next negedge showing a strobe.
  task automatic wait_strobe(output int waited, output bit seen);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 200) begin
      @(negedge clk);
      waited++;
      if (pio_chipselect === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic count_strobes(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (pio_chipselect !== 1'b0) cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    nchecks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 8'h00 ||
        busy !== 1'b0 || pio_address !== 2'd0) begin
      nerr++;
      $display("FAIL reset_state: cs=%b wn=%b data=%h busy=%b addr=%0d, required 0 1 00 0 0",
               pio_chipselect, pio_write_n, pio_writedata, busy, pio_address);
    end
    reset = 1'b0;
  endtask

  task automatic test_disabled_pattern;
    int cnt;
    cpu_write(2'd1, 8'h3C);
    nchecks++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_writedata !== 8'h3C || busy !== 1'b1) begin
      nerr++;
      $display("FAIL seed_strobe: cs=%b wn=%b data=%h busy=%b, required 1 0 3c 1",
               pio_chipselect, pio_write_n, pio_writedata, busy);
    end
    cpu_write(2'd3, 8'h07);
    count_strobes(1000, cnt);
    nchecks++;
    if (cnt != 0 || pio_writedata !== 8'h3C || busy !== 1'b0) begin
      nerr++;
      $display("FAIL seed_quiet: strobes=%0d data=%h busy=%b, required 0 3c 0", cnt, pio_writedata, busy);
    end
  endtask

  task automatic test_rotate;
    logic [7:0] exp [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    int waited;
    bit seen;
    cpu_write(2'd2, 8'd1);
    cpu_write(2'd1, 8'h81);
    nchecks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 8'h81) begin
      nerr++;
      $display("FAIL rotate_seed: cs=%b data=%h, required 1 81", pio_chipselect, pio_writedata);
    end
    cpu_write(2'd0, 8'h03);
    for (int i = 0; i < 8; i++) begin
      wait_strobe(waited, seen);
      nchecks++;
      if (!seen || pio_writedata !== exp[i] || pio_write_n !== 1'b0 || waited != 8) begin
        nerr++;
        $display("FAIL rotate[%0d]: seen=%b data=%h gap=%0d, required data %h gap 8",
                 i, seen, pio_writedata, waited, exp[i]);
      end
    end
    cpu_write(2'd0, 8'h00);
  endtask

  task automatic test_bounce;
    logic [7:0] exp [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    int waited;
    bit seen;
    cpu_write(2'd2, 8'd0);
    cpu_write(2'd1, 8'h01);
    cpu_write(2'd0, 8'h05);
    for (int i = 0; i < 16; i++) begin
      wait_strobe(waited, seen);
      nchecks++;
      if (!seen || pio_writedata !== exp[i] || waited != 4) begin
        nerr++;
        $display("FAIL bounce[%0d]: seen=%b data=%h gap=%0d, required data %h gap 4",
                 i, seen, pio_writedata, waited, exp[i]);
      end
    end
    cpu_write(2'd0, 8'h00);
  endtask

  task automatic test_count_and_collisions;
    logic [7:0] exp [3] = '{8'hFF, 8'h00, 8'h01};
    int waited;
    int cnt;
    bit seen;
    cpu_write(2'd1, 8'hFE);
    cpu_write(2'd0, 8'h07);
    for (int i = 0; i < 3; i++) begin
      wait_strobe(waited, seen);
      nchecks++;
      if (!seen || pio_writedata !== exp[i] || waited != 4) begin
        nerr++;
        $display("FAIL count[%0d]: seen=%b data=%h gap=%0d, required data %h gap 4",
                 i, seen, pio_writedata, waited, exp[i]);
      end
    end
    // Seed write lands in the tick cycle (three cycles after the last strobe).
    repeat (2) @(negedge clk);
    cpu_write(2'd1, 8'h10);
    nchecks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 8'h10) begin
      nerr++;
      $display("FAIL seed_on_tick: cs=%b data=%h, required 1 10", pio_chipselect, pio_writedata);
    end
    wait_strobe(waited, seen);
    nchecks++;
    if (!seen || pio_writedata !== 8'h11 || waited != 4) begin
      nerr++;
      $display("FAIL after_seed_tick: seen=%b data=%h gap=%0d, required 11 gap 4",
               seen, pio_writedata, waited);
    end
    nchecks++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL busy_running: busy=%b, required 1", busy);
    end
    // Disable lands in the tick cycle: no strobe, busy low right after.
    repeat (2) @(negedge clk);
    cpu_write(2'd0, 8'h06);
    nchecks++;
    if (pio_chipselect !== 1'b0 || busy !== 1'b0 || pio_writedata !== 8'h11) begin
      nerr++;
      $display("FAIL disable_on_tick: cs=%b busy=%b data=%h, required 0 0 11",
               pio_chipselect, busy, pio_writedata);
    end
    count_strobes(40, cnt);
    nchecks++;
    if (cnt != 0) begin
      nerr++;
      $display("FAIL disabled_quiet: strobes=%0d, required 0", cnt);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    cpu_chipselect = 1'b1;
    cpu_write_n    = 1'b0;
    cpu_address    = 2'd1;
    cpu_writedata  = 8'h11;
    @(negedge clk);
    nchecks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 8'h11) begin
      nerr++;
      $display("FAIL b2b_first: cs=%b data=%h, required 1 11", pio_chipselect, pio_writedata);
    end
    cpu_writedata = 8'h22;
    @(negedge clk);
    cpu_chipselect = 1'b0;
    cpu_write_n    = 1'b1;
    nchecks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 8'h22) begin
      nerr++;
      $display("FAIL b2b_second: cs=%b data=%h, required 1 22", pio_chipselect, pio_writedata);
    end
    @(negedge clk);
    nchecks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 8'h22) begin
      nerr++;
      $display("FAIL b2b_end: cs=%b wn=%b data=%h, required 0 1 22",
               pio_chipselect, pio_write_n, pio_writedata);
    end
  endtask

  task automatic test_reset_mid_strobe;
    int cnt;
    int waited;
    bit seen;
    cpu_write(2'd2, 8'd5);
    cpu_write(2'd1, 8'hA5);
    nchecks++;
    if (pio_chipselect !== 1'b1 || pio_writedata !== 8'hA5) begin
      nerr++;
      $display("FAIL pre_reset_strobe: cs=%b data=%h, required 1 a5", pio_chipselect, pio_writedata);
    end
    reset = 1'b1;
    #1;
    nchecks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 8'h00 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL async_reset: cs=%b wn=%b data=%h busy=%b, required 0 1 00 0",
               pio_chipselect, pio_write_n, pio_writedata, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    count_strobes(50, cnt);
    nchecks++;
    if (cnt != 0) begin
      nerr++;
      $display("FAIL post_reset_quiet: strobes=%0d, required 0", cnt);
    end
    // Pattern and rate back at 0: rotate of 0 still writes 00 every 4 cycles.
    cpu_write(2'd0, 8'h03);
    wait_strobe(waited, seen);
    nchecks++;
    if (!seen || pio_writedata !== 8'h00 || waited != 4) begin
      nerr++;
      $display("FAIL post_reset_rotate: seen=%b data=%h gap=%0d, required 00 gap 4",
               seen, pio_writedata, waited);
    end
    cpu_write(2'd0, 8'h00);
  endtask

  initial begin
    reset          = 1'b1;
    cpu_address    = 2'd0;
    cpu_chipselect = 1'b0;
    cpu_write_n    = 1'b1;
    cpu_writedata  = 8'h00;
    test_reset();
    test_disabled_pattern();
    test_rotate();
    test_bounce();
    test_count_and_collisions();
    test_back_to_back();
    test_reset_mid_strobe();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
